// File: rtl/pixel_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer_pkg
// Description : Shared types and constants for the pixel packer: the packing
//               FSM state encoding and the AXI-Stream word width.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_packer_pkg;

  localparam int AXIS_W = 128;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PACK     = 2'd1,
    DROP     = 2'd2
  } pp_state_t;

endpackage : pixel_packer_pkg
`default_nettype wire

// File: rtl/pp_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : pp_skid_fifo2
// Description : Two-entry output buffer carrying a data word plus its TLAST
//               bit. A push while full is accepted only when a pop happens in
//               the same cycle; otherwise the pushed word is discarded and
//               the caller is expected to flag the loss using o_full.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_skid_fifo2 #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic [DATA_W-1:0] r_mem_data [2];
  logic              r_mem_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic w_pop;
  logic w_push;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
  assign o_full  = (r_count == 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem_data[r_rd_ptr];
  assign o_last  = r_mem_last[r_rd_ptr];

  // Storage and pointer/occupancy bookkeeping; head entry stays put until popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_data[i] <= '0;
        r_mem_last[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= i_data;
        r_mem_last[r_wr_ptr] <= i_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : pp_skid_fifo2
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Packs a free-running camera pixel stream into 128-bit
//               AXI-Stream words with TLAST on the final word of each frame.
//               Short frames are closed early with a zero-padded TLAST word,
//               long-frame pixels are discarded, and a lost word forces the
//               packer to resynchronise on the next SOF.
//               Optional macro PIXEL_PACKER_STATS_EN enables the frame and
//               short-frame statistics counters (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 360
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pix_valid_in,
  input  logic [PIX_W-1:0]  pix_data_in,
  input  logic              pix_sof_in,
  output logic [AXIS_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  output logic              m_axis_tlast,
  input  logic              m_axis_ready,
  output logic              overflow_out,
  output logic              frame_err_out,
  input  logic              clr_err_in,
  output logic [15:0]       frame_count_out,
  output logic [15:0]       short_count_out
);

  localparam int LANES       = AXIS_W / PIX_W;
  localparam int FRAME_WORDS = (H_ACTIVE * V_ACTIVE) / LANES;
  localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WC_W        = ($clog2(FRAME_WORDS) > 14) ? $clog2(FRAME_WORDS) : 14;

  pp_state_t         r_state;
  pp_state_t         w_state_nxt;
  logic [LANE_W-1:0] r_lane;
  logic [LANE_W-1:0] w_lane_nxt;
  logic [WC_W-1:0]   r_word;
  logic [WC_W-1:0]   w_word_nxt;
  logic [AXIS_W-1:0] r_acc;
  logic [AXIS_W-1:0] w_acc_nxt;
  logic [AXIS_W-1:0] w_pix_ins;
  logic [AXIS_W-1:0] w_pix_first;
  logic              r_after_last;
  logic              w_after_last_nxt;

  logic              w_push;
  logic [AXIS_W-1:0] w_push_data;
  logic              w_push_last;
  logic              w_err_set;
  logic              w_short_inc;
  logic              w_ovf_set;

  logic              w_lane_last;
  logic              w_word_last;
  logic              w_mid_frame;

  logic              w_full;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [AXIS_W-1:0] w_fifo_data;
  logic              w_fifo_last;

  logic              r_overflow;
  logic              r_frame_err;

  // Accumulator always holds zeros above the current lane, so a partial word
  // is already zero-padded and a lane-0 flush is naturally all-zero.
  assign w_pix_ins   = r_acc | (AXIS_W'(pix_data_in) << (int'(r_lane) * PIX_W));
  assign w_pix_first = AXIS_W'(pix_data_in);
  assign w_lane_last = (r_lane == LANE_W'(LANES - 1));
  assign w_word_last = (r_word == WC_W'(FRAME_WORDS - 1));
  assign w_mid_frame = (r_word != '0) || (r_lane != '0);
  assign w_pop       = w_fifo_valid && m_axis_ready;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control: packing, early-SOF flush, long-frame
  // detection; a word lost to a full buffer overrides everything with DROP.
  always_comb begin
    w_state_nxt      = r_state;
    w_lane_nxt       = r_lane;
    w_word_nxt       = r_word;
    w_acc_nxt        = r_acc;
    w_after_last_nxt = r_after_last;
    w_push           = 1'b0;
    w_push_data      = w_pix_ins;
    w_push_last      = 1'b0;
    w_err_set        = 1'b0;
    w_short_inc      = 1'b0;
    w_ovf_set        = 1'b0;

    if (pix_valid_in) begin
      case (r_state)
        WAIT_SOF, DROP: begin
          if (pix_sof_in) begin
            w_state_nxt      = PACK;
            w_acc_nxt        = w_pix_first;
            w_lane_nxt       = LANE_W'(1);
            w_word_nxt       = '0;
            w_after_last_nxt = 1'b0;
          end else if ((r_state == WAIT_SOF) && r_after_last) begin
            w_err_set = 1'b1;
          end
        end
        PACK: begin
          if (pix_sof_in && w_mid_frame) begin
            w_push           = 1'b1;
            w_push_data      = r_acc;
            w_push_last      = 1'b1;
            w_err_set        = 1'b1;
            w_short_inc      = 1'b1;
            w_acc_nxt        = w_pix_first;
            w_lane_nxt       = LANE_W'(1);
            w_word_nxt       = '0;
            w_after_last_nxt = 1'b0;
          end else if (w_lane_last) begin
            w_push      = 1'b1;
            w_push_data = w_pix_ins;
            w_push_last = w_word_last;
            w_acc_nxt   = '0;
            w_lane_nxt  = '0;
            if (w_word_last) begin
              w_word_nxt       = '0;
              w_state_nxt      = WAIT_SOF;
              w_after_last_nxt = 1'b1;
            end else begin
              w_word_nxt = r_word + WC_W'(1);
            end
          end else begin
            w_acc_nxt  = w_pix_ins;
            w_lane_nxt = r_lane + LANE_W'(1);
          end
        end
        default: begin
          w_state_nxt = WAIT_SOF;
        end
      endcase
    end

    if (w_push && w_full && !w_pop) begin
      w_ovf_set   = 1'b1;
      w_state_nxt = DROP;
      w_acc_nxt   = '0;
      w_lane_nxt  = '0;
      w_word_nxt  = '0;
    end
  end

  // Lane/word counters, accumulator and long-frame tracking.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_lane       <= '0;
      r_word       <= '0;
      r_acc        <= '0;
      r_after_last <= 1'b0;
    end else begin
      r_lane       <= w_lane_nxt;
      r_word       <= w_word_nxt;
      r_acc        <= w_acc_nxt;
      r_after_last <= w_after_last_nxt;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (clr_err_in) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_set) r_overflow  <= 1'b1;
      if (w_err_set) r_frame_err <= 1'b1;
    end
  end

  pp_skid_fifo2 #(
    .DATA_W (AXIS_W)
  ) u_out_buf (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_last  (w_push_last),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_last  (w_fifo_last)
  );

  assign m_axis_valid  = w_fifo_valid;
  assign m_axis_data   = w_fifo_data;
  assign m_axis_tlast  = w_fifo_last;
  assign overflow_out  = r_overflow;
  assign frame_err_out = r_frame_err;

`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_short_cnt;

  // Frames are counted when their TLAST word leaves; short frames on detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_cnt <= '0;
      r_short_cnt <= '0;
    end else begin
      if (w_pop && w_fifo_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_short_inc)          r_short_cnt <= r_short_cnt + 16'd1;
    end
  end

  assign frame_count_out = r_frame_cnt;
  assign short_count_out = r_short_cnt;
`else
  logic w_unused_short;
  assign w_unused_short  = w_short_inc;
  assign frame_count_out = '0;
  assign short_count_out = '0;
`endif

endmodule : pixel_packer
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_packer
// Description : Self-checking bench for pixel_packer with a 32x2 frame
//               (4 words per frame). Directed scenarios followed by random
//               frames, all compared against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_packer;

  localparam int PIX_W = 8;
  localparam int H     = 32;
  localparam int V     = 2;
  localparam int LANES = 16;
  localparam int FW    = (H * V) / LANES;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         pix_valid_in;
  logic [7:0]   pix_data_in;
  logic         pix_sof_in;
  logic         m_axis_ready;
  logic         clr_err_in;
  logic [127:0] m_axis_data;
  logic         m_axis_valid;
  logic         m_axis_tlast;
  logic         overflow_out;
  logic         frame_err_out;
  logic [15:0]  frame_count_out;
  logic [15:0]  short_count_out;

  always #5 clk_in = ~clk_in;

  pixel_packer #(
    .PIX_W    (PIX_W),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .pix_valid_in    (pix_valid_in),
    .pix_data_in     (pix_data_in),
    .pix_sof_in      (pix_sof_in),
    .m_axis_data     (m_axis_data),
    .m_axis_valid    (m_axis_valid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_ready    (m_axis_ready),
    .overflow_out    (overflow_out),
    .frame_err_out   (frame_err_out),
    .clr_err_in      (clr_err_in),
    .frame_count_out (frame_count_out),
    .short_count_out (short_count_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } word_t;

  word_t       m_buf[$];
  logic [7:0]  m_cur[$];
  int          m_mode;    // 0 idle, 1 in frame, 2 dropping
  int          m_wcnt;
  bit          m_after;
  bit          m_ovf;
  bit          m_err;
  logic [15:0] m_fc;
  logic [15:0] m_sc;

  function automatic logic [127:0] pack_cur();
    logic [127:0] w = '0;
    foreach (m_cur[i]) w[i*8 +: 8] = m_cur[i];
    return w;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_cur.delete();
    m_mode  = 0;
    m_wcnt  = 0;
    m_after = 0;
    m_ovf   = 0;
    m_err   = 0;
    m_fc    = '0;
    m_sc    = '0;
  endtask

  task automatic model_step();
    bit pop, full, have_push, plast, start, err_s, ovf_s;
    logic [127:0] pdata;
    pop = (m_buf.size() != 0) && m_axis_ready;
    full = (m_buf.size() == 2);
    have_push = 0; plast = 0; start = 0; err_s = 0; ovf_s = 0; pdata = '0;
    if (pix_valid_in) begin
      if (pix_sof_in) begin
        if (m_mode == 1 && (m_wcnt != 0 || m_cur.size() != 0)) begin
          have_push = 1; pdata = pack_cur(); plast = 1; err_s = 1; m_sc++;
        end
        start = 1;
      end else if (m_mode == 1) begin
        m_cur.push_back(pix_data_in);
        if (m_cur.size() == LANES) begin
          have_push = 1; pdata = pack_cur(); plast = (m_wcnt == FW - 1);
          m_cur.delete();
          if (plast) begin m_mode = 0; m_wcnt = 0; m_after = 1; end
          else m_wcnt++;
        end
      end else if (m_mode == 0 && m_after) begin
        err_s = 1;
      end
    end
    if (pop) begin
      if (m_buf[0].last) m_fc++;
      void'(m_buf.pop_front());
    end
    if (have_push) begin
      if (full && !pop) begin
        ovf_s = 1; m_mode = 2; m_cur.delete(); m_wcnt = 0; start = 0;
      end else begin
        m_buf.push_back({pdata, plast});
      end
    end
    if (start) begin
      m_mode = 1; m_cur.delete(); m_cur.push_back(pix_data_in); m_wcnt = 0; m_after = 0;
    end
    if (clr_err_in) begin
      m_ovf = 0; m_err = 0;
    end else begin
      if (ovf_s) m_ovf = 1;
      if (err_s) m_err = 1;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] efc, esc;
`ifdef PIXEL_PACKER_STATS_EN
    efc = m_fc; esc = m_sc;
`else
    efc = '0; esc = '0;
`endif
    chk("valid", m_axis_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      chk("data", m_axis_data, m_buf[0].d);
      chk("tlast", m_axis_tlast, m_buf[0].last);
    end
    chk("overflow", overflow_out, m_ovf);
    chk("frame_err", frame_err_out, m_err);
    chk("frame_count", frame_count_out, efc);
    chk("short_count", short_count_out, esc);
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit s, input bit r, input bit c);
    pix_valid_in = v; pix_data_in = d; pix_sof_in = s; m_axis_ready = r; clr_err_in = c;
    @(posedge clk_in);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, m_axis_valid, 0);
    chk({tag, "_data"}, m_axis_data, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_ovf"}, overflow_out, 0);
    chk({tag, "_err"}, frame_err_out, 0);
    chk({tag, "_fc"}, frame_count_out, 0);
    chk({tag, "_sc"}, short_count_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w0;
    w0 = 128'h0f0e0d0c0b0a09080706050403020100;
    rst_n_in = 1'b0; pix_valid_in = 1'b0; pix_data_in = '0; pix_sof_in = 1'b0;
    m_axis_ready = 1'b1; clr_err_in = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    idle(2);

    // Nominal frame
    cyc(1, 8'h00, 1, 1, 0);
    for (int p = 1; p < 64; p++) begin
      cyc(1, 8'(p), 0, 1, 0);
      if (p == 15) chk("nom_word0", m_axis_data, w0);
    end
    idle(4);

    // Backpressure leading to overflow, then a clean frame
    cyc(1, 8'h40, 1, 1, 0);
    for (int p = 1; p < 64; p++) cyc(1, 8'(8'h40 + p), 0, !(p >= 8 && p < 48), 0);
    chk("bp_ovf", overflow_out, 1);
    idle(4);
    cyc(1, 8'h80, 1, 1, 0);
    for (int p = 1; p < 64; p++) cyc(1, 8'(8'h80 + p), 0, 1, 0);
    idle(4);
    cyc(0, 8'h00, 0, 1, 1);

    // Short frame, then a full frame started by the second SOF
    cyc(1, 8'h00, 1, 1, 0);
    for (int p = 1; p < 20; p++) cyc(1, 8'(p), 0, 1, 0);
    cyc(1, 8'hA0, 1, 1, 0);
    chk("short_err", frame_err_out, 1);
    for (int p = 1; p < 64; p++) cyc(1, 8'(8'hA0 + p), 0, 1, 0);
    idle(4);
    cyc(0, 8'h00, 0, 1, 1);

    // Long frame
    cyc(1, 8'h10, 1, 1, 0);
    for (int p = 1; p < 70; p++) cyc(1, 8'(8'h10 + p), 0, 1, 0);
    chk("long_err", frame_err_out, 1);
    idle(4);

    // Clear priority against an early SOF
    cyc(0, 8'h00, 0, 1, 1);
    cyc(1, 8'h20, 1, 1, 0);
    for (int p = 1; p < 6; p++) cyc(1, 8'(8'h20 + p), 0, 1, 0);
    cyc(1, 8'h55, 1, 1, 1);
    chk("clr_prio", frame_err_out, 0);
    for (int p = 1; p < 64; p++) cyc(1, 8'(8'h55 + p), 0, 1, 0);
    idle(4);

    // Asynchronous reset mid-word with valid high
    cyc(1, 8'h30, 1, 1, 0);
    for (int p = 1; p < 8; p++) cyc(1, 8'(8'h30 + p), 0, 1, 0);
    pix_valid_in = 1'b1; pix_data_in = 8'h99;
    #2;
    rst_n_in = 1'b0;
    #1;
    chk_all_zero("areset");
    model_reset();
    @(posedge clk_in); @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    for (int p = 0; p < 20; p++) cyc(1, 8'($urandom), 0, 1, 0);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      int len, sel, sent;
      sel = $urandom_range(0, 9);
      if (sel < 6)      len = 64;
      else if (sel < 8) len = $urandom_range(1, 63);
      else              len = $urandom_range(65, 80);
      sent = 0;
      while (sent < len) begin
        bit rdy, clr;
        rdy = ($urandom_range(0, 9) < 7);
        clr = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 4) == 0) begin
          cyc(0, 8'($urandom), 1'($urandom), rdy, clr);
        end else begin
          cyc(1, 8'($urandom), (sent == 0), rdy, clr);
          sent++;
        end
      end
      for (int g = 0; g < int'($urandom_range(0, 6)); g++) cyc(0, 8'($urandom), 0, 1, 0);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pixel_packer
`default_nettype wire

// File: doc/pixel_packer.md
# pixel_packer

Packs a free-running camera pixel stream into 128-bit AXI-Stream words for the DDR3 write arbiter. It sits between the camera capture logic and the camera write FIFO that feeds the arbiter's `wr_cam*_axis` port. It asserts TLAST on the last word of every frame, which resets the arbiter's write address. Malformed frames are forced to a well-formed word count, so the DRAM frame buffer never drifts out of alignment.

## Interface
Parameters:
- `PIX_W`, 8: bits per pixel (grayscale).
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 360: lines per frame.
- Derived: `LANES` = 128/`PIX_W` (16); `FRAME_WORDS` = `H_ACTIVE`·`V_ACTIVE`/`LANES` (14400). `H_ACTIVE`·`V_ACTIVE` must be a multiple of `LANES`.

Ports:
- `clk_in`, in, 1: camera-domain clock.
- `rst_n_in`, in, 1: reset, asynchronous, active-low.
- `pix_valid_in`, in, 1: pixel strobe; cannot be back-pressured.
- `pix_data_in`, in, `PIX_W`: pixel value.
- `pix_sof_in`, in, 1: first pixel of frame; qualified by `pix_valid_in`.
- `m_axis_data`, out, 128: packed word.
- `m_axis_valid`, out, 1: word available.
- `m_axis_tlast`, out, 1: last word of frame.
- `m_axis_ready`, in, 1: downstream FIFO ready.
- `overflow_out`, out, 1: sticky; a completed word was dropped.
- `frame_err_out`, out, 1: sticky; a short or long frame was seen.
- `clr_err_in`, in, 1: synchronous clear of both sticky flags.
- `frame_count_out`, out, 16: frames completed with TLAST.
- `short_count_out`, out, 16: short frames seen.

## Operation
- **States** (all in `pp_state_t`):
  - `WAIT_SOF`: reset state. Discards pixels until a valid pixel carries SOF, which goes to `PACK` as lane 0 of word 0.
  - `PACK`: accumulates pixels.
  - `DROP`: entered on overflow. Discards pixels until the next SOF, then behaves as `WAIT_SOF`.
- **Lane order**: first pixel in bits [7:0], sixteenth in [127:120]. Lane counter is 0..`LANES`-1. Word counter is 0..`FRAME_WORDS`-1, 14 bits minimum.
- **Word completion**: when lane 15 is accepted, the word is pushed to the output buffer.
  - TLAST = (word counter == `FRAME_WORDS`-1).
  - On a TLAST word, the word counter resets and the state goes to `WAIT_SOF`.
  - Extra pixels after that, before the next SOF (long frame), are discarded and set `frame_err_out`.
- **Early SOF** (SOF in `PACK` with word counter ≠ 0 or lane ≠ 0): push one TLAST word containing the partial data zero-padded. If the lane count is 0, push an all-zero word. This sets `frame_err_out` and increments `short_count_out`. The SOF pixel then starts a new frame at lane 0 in the same cycle. SOF at exactly lane 0 of word 0 is normal.
- **Output buffer**: two entries.
  - A push while both entries are full drops the new word, sets `overflow_out`, and moves to `DROP`.
  - A simultaneous push and pop while full succeeds.
- **Handshake**: once `m_axis_valid` is high, data, TLAST and valid hold until `m_axis_ready` is seen.
- **Counters**: all wrap at 2^16.
- **Error flags**: `clr_err_in` has priority over a same-cycle set.

## Timing
- **Reset**: state `WAIT_SOF`. All outputs are 0: valid, data, tlast, flags and counters. The buffer is emptied and the lane and word counters are zeroed.
- **Latency**: a word is visible on `m_axis_valid` one cycle after its 16th pixel is accepted, with the buffer empty.
- **Throughput**: one word per cycle when `m_axis_ready` is held high.
- **Counter timing**: `frame_count_out` increments in the cycle a TLAST word is popped.
- **Mid-frame reset**: abandons the frame with no TLAST emitted. The arbiter is expected to share this reset.

## Configuration
- **`PIXEL_PACKER_STATS_EN` defined**: `frame_count_out` and `short_count_out` are live.
- **`PIXEL_PACKER_STATS_EN` undefined**: both ports are tied to 0 and the counters are not synthesised.
- Sticky flags and all packing behaviour are unaffected by the macro.

## Structure
- **`pixel_packer_pkg`**: `pp_state_t` enum and the `AXIS_W` = 128 constant.
- **`pp_skid_fifo2`**: one sub-module for the 2-entry output buffer. It carries data + TLAST with push/full/pop/valid, and its full flag drives overflow.

## Test plan
All scenarios use `H_ACTIVE`=32, `V_ACTIVE`=2, giving 4 words per frame.
- **Nominal frame**: SOF, then pixels 0x00..0x3F, ready=1 → 4 words. Word 0 = 0x0F0E…0100, TLAST only on word 3, frame_count=1.
- **Backpressure**: ready=0 for 40 cycles mid-frame → two words held and stable. The third completed word sets `overflow_out` and state goes to `DROP`. The next SOF frame packs correctly.
- **Short frame**: SOF, 20 pixels, SOF → word 1 = pixels 16..19 zero-padded with TLAST. short_count=1, `frame_err_out`=1. The new frame starts at lane 0.
- **Long frame**: 70 pixels after SOF → 4 words, last with TLAST. Pixels 64..69 are discarded and `frame_err_out`=1.
- **Async reset**: assert `rst_n_in` mid-word with valid high → all outputs 0 immediately. Pixels without SOF after release produce no output.
- **Clear priority**: `clr_err_in` asserted in the same cycle as an early SOF → flag is 0 afterwards.
